// File: rtl/multi_tap_recorder.sv
// Audio take recorder with multi-tap echo playback over a circular sample buffer.
// Optional build macro MULTI_TAP_RECORDER_SATURATE_EN clamps the mixed output instead of wrapping.
module multi_tap_recorder #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 16,
  parameter int NUM_TAPS = 3
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic signed [WIDTH-1:0]      audio_in,
  input  logic                         audio_valid_in,
  input  logic                         record_in,
  input  logic                         play_in,
  input  logic [NUM_TAPS*ADDR_W-1:0]   tap_delay_in,
  input  logic [NUM_TAPS*3-1:0]        tap_shift_in,
  output logic signed [WIDTH-1:0]      audio_out,
  output logic                         audio_valid_out,
  output logic [ADDR_W:0]              length_out,
  output logic                         full_out,
  output logic                         busy_out,
  output logic                         overrun_out
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int ACC_W = WIDTH + $clog2(NUM_TAPS) + 1;
  localparam int CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [ADDR_W:0]   LEN_MAX    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   PLAYED_MAX = '1;
  localparam logic [CNT_W-1:0]  LAST_TAP   = CNT_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     record_q, play_q;
  logic                     rec_rise, rec_stb, play_stb, play_go, ptr_clr;
  logic [ADDR_W-1:0]        wr_ptr, wr_base, rd_ptr, base, rd_addr;
  logic [ADDR_W:0]          length, len_base, played, played_lat, len_lat;
  logic                     overrun;
  logic [ADDR_W-1:0]        sel_delay;
  logic [2:0]               sel_shift;
  logic                     tap_en;
  logic signed [WIDTH-1:0]  mem [DEPTH];
  logic signed [WIDTH-1:0]  rd_data_p0;
  logic                     vld_p0, en_p0;
  logic [2:0]               shift_p0;
  logic signed [ACC_W-1:0]  acc_p1;

  function automatic logic signed [ACC_W-1:0] tap_term(input logic signed [WIDTH-1:0] d,
                                                       input logic [2:0] sh,
                                                       input logic en);
    logic signed [WIDTH-1:0] a;
    a = d >>> sh;
    return en ? {{(ACC_W-WIDTH){a[WIDTH-1]}}, a} : '0;
  endfunction

`ifdef MULTI_TAP_RECORDER_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] to_out(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI)      return SAT_HI[WIDTH-1:0];
    else if (a < SAT_LO) return SAT_LO[WIDTH-1:0];
    else                 return a[WIDTH-1:0];
  endfunction
`else
  function automatic logic signed [WIDTH-1:0] to_out(input logic signed [ACC_W-1:0] a);
    return a[WIDTH-1:0];
  endfunction
`endif

  assign rec_rise = record_in & ~record_q;
  assign rec_stb  = audio_valid_in & record_in;
  assign play_stb = audio_valid_in & ~record_in & play_in;
  assign play_go  = play_stb & (state == IDLE);
  assign ptr_clr  = rec_rise | (play_q & ~play_in);
  // A strobe coinciding with the record rising edge is the first sample of the new take.
  assign wr_base  = rec_rise ? '0 : wr_ptr;
  assign len_base = rec_rise ? '0 : length;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      record_q <= 1'b0;
      wr_ptr   <= '0;
      length   <= '0;
    end else begin
      record_q <= record_in;
      if (rec_stb) begin
        wr_ptr <= wr_base + 1'b1;
        length <= (len_base == LEN_MAX) ? len_base : len_base + 1'b1;
      end else if (rec_rise) begin
        wr_ptr <= '0;
        length <= '0;
      end
    end
  end

  // Read-first simple dual-port RAM, not reset.
  always_ff @(posedge clk_in) begin
    if (rec_stb)
      mem[wr_base] <= audio_in;
    rd_data_p0 <= mem[rd_addr];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      play_q     <= 1'b0;
      rd_ptr     <= '0;
      played     <= '0;
      base       <= '0;
      played_lat <= '0;
      len_lat    <= '0;
      overrun    <= 1'b0;
    end else begin
      play_q <= play_in;
      if (ptr_clr) begin
        rd_ptr <= '0;
        played <= '0;
      end else if (play_go) begin
        rd_ptr <= (({1'b0, rd_ptr} + 1'b1) >= length) ? '0 : rd_ptr + 1'b1;
        played <= (played == PLAYED_MAX) ? played : played + 1'b1;
      end
      if (play_go) begin
        base       <= rd_ptr;
        played_lat <= played;
        len_lat    <= length;
      end
      if (play_stb && (state != IDLE))
        overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (play_go) begin
        state_nxt = READ;
        cnt_nxt   = '0;
      end
      READ: begin
        if (cnt == LAST_TAP) state_nxt = DRAIN;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      DRAIN:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_delay = '0;
    sel_shift = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (cnt == CNT_W'(k)) begin
        sel_delay = tap_delay_in[k*ADDR_W +: ADDR_W];
        sel_shift = tap_shift_in[k*3 +: 3];
      end
    end
  end

  assign rd_addr = base - sel_delay;
  // Echo taps stay silent until playback has advanced past their delay and the take is long enough.
  assign tap_en  = (sel_shift != 3'd7) && ({1'b0, sel_delay} <= played_lat) &&
                   ({1'b0, sel_delay} < len_lat);

  // p0: RAM word returns with its tap enable and shift
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) vld_p0 <= 1'b0;
    else           vld_p0 <= (state == READ);
  end

  always_ff @(posedge clk_in) begin
    en_p0    <= tap_en;
    shift_p0 <= sel_shift;
  end

  // p1: accumulate one tap per cycle
  always_ff @(posedge clk_in) begin
    if (play_go)     acc_p1 <= '0;
    else if (vld_p0) acc_p1 <= acc_p1 + tap_term(rd_data_p0, shift_p0, en_p0);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      audio_out       <= '0;
      audio_valid_out <= 1'b0;
    end else begin
      audio_valid_out <= (state == OUT);
      if (state == OUT)
        audio_out <= to_out(acc_p1);
    end
  end

  assign length_out  = length;
  assign full_out    = (length == LEN_MAX);
  assign busy_out    = (state != IDLE);
  assign overrun_out = overrun;

endmodule
